// File: rtl/operand_hazard_ctrl_if.sv
// Issue-slot bundle between decode and the operand hazard controller, including
// the long-unit writeback, the redirect signals and the scheduler's status back to decode.
interface operand_hazard_ctrl_if #(
    parameter int NREG = 32
);
    logic            issue_valid;
    logic [4:0]      issue_ra1;
    logic [4:0]      issue_ra2;
    logic            issue_use1;
    logic            issue_use2;
    logic [4:0]      issue_wa;
    logic            issue_wen;
    logic [1:0]      issue_cls;
    logic            long_done;
    logic [4:0]      long_wa;
    logic            flush;
    logic            long_kill;
    logic            stall;
    logic            issue_fire;
    logic            long_busy;
    logic [NREG-1:0] pending_mask;

    modport master (
        output issue_valid, issue_ra1, issue_ra2, issue_use1, issue_use2,
               issue_wa, issue_wen, issue_cls, long_done, long_wa, flush, long_kill,
        input  stall, issue_fire, long_busy, pending_mask
    );

    modport slave (
        input  issue_valid, issue_ra1, issue_ra2, issue_use1, issue_use2,
               issue_wa, issue_wen, issue_cls, long_done, long_wa, flush, long_kill,
        output stall, issue_fire, long_busy, pending_mask
    );
endinterface

// File: rtl/operand_hazard_ctrl.sv
// Issue-stage scheduler: tracks in-flight load/long results per register, stalls
// instructions the forwarding network cannot yet satisfy, and owns the single long unit.
module operand_hazard_ctrl #(
    parameter int NREG     = 32,
    parameter int LOAD_LAT = 1,
    parameter int CW       = 2
) (
    input logic               clk,
    input logic               reset,
    operand_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_LOAD = 2'd1,
        CLS_LONG = 2'd2,
        CLS_RSVD = 2'd3
    } op_class_e;

    localparam logic [CW-1:0] LOAD_INIT = CW'(LOAD_LAT);

    logic [CW-1:0]   cnt [NREG];
    logic            long_busy;
    logic [4:0]      long_tag;
    logic [NREG-1:0] hazard;
    logic [NREG-1:0] pending;
    logic            stall_int;
    logic            fire_int;
    op_class_e       cls;

    assign cls = op_class_e'(bus.issue_cls);

    // A long op writing back this very cycle is picked up by W-stage forwarding.
    always_comb begin
        hazard = '0;
        for (int r = 1; r < NREG; r++) begin
            hazard[r] = (cnt[r] != '0) ||
                        (long_busy && (long_tag == 5'(r)) &&
                         !(bus.long_done && (bus.long_wa == 5'(r))));
        end
    end

    always_comb begin
        pending = '0;
        for (int r = 1; r < NREG; r++) begin
            pending[r] = (cnt[r] != '0) || (long_busy && (long_tag == 5'(r)));
        end
    end

    always_comb begin
        stall_int = 1'b0;
        fire_int  = 1'b0;
        if (!reset && bus.issue_valid && !bus.flush) begin
            stall_int = (bus.issue_use1 && hazard[bus.issue_ra1]) ||
                        (bus.issue_use2 && hazard[bus.issue_ra2]) ||
                        (bus.issue_wen  && hazard[bus.issue_wa])  ||
                        ((cls == CLS_LONG) && long_busy && !bus.long_done);
            fire_int  = !stall_int;
        end
    end

    assign bus.stall        = stall_int;
    assign bus.issue_fire   = fire_int;
    assign bus.long_busy    = long_busy;
    assign bus.pending_mask = pending;

    // Countdowns keep draining through stalls; a new load or long issue overrides
    // the decrement and any same-cycle completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
            long_busy <= 1'b0;
            long_tag  <= '0;
        end else if (bus.flush) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
            if (bus.long_kill) long_busy <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (cnt[r] != '0) cnt[r] <= cnt[r] - CW'(1);
            end
            if (bus.long_done && long_busy && (bus.long_wa == long_tag)) long_busy <= 1'b0;
            if (fire_int && (cls == CLS_LOAD) && bus.issue_wen && (bus.issue_wa != 5'd0)) begin
                cnt[bus.issue_wa] <= LOAD_INIT;
            end
            if (fire_int && (cls == CLS_LONG) && bus.issue_wen) begin
                long_busy <= 1'b1;
                long_tag  <= bus.issue_wa;
            end
        end
    end
endmodule

// File: tb/tb_operand_hazard_ctrl.sv
// Self-checking bench for operand_hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a register-scoreboard model of in-flight results.
module tb_operand_hazard_ctrl;
    localparam int NREG     = 32;
    localparam int LOAD_LAT = 1;

    logic clk = 1'b0;
    logic reset;

    operand_hazard_ctrl_if #(.NREG(NREG)) bus ();

    operand_hazard_ctrl #(.NREG(NREG), .LOAD_LAT(LOAD_LAT), .CW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard: cycles each register's load result is still unforwardable, plus
    // the one outstanding long op (if any) and its destination.
    int ld_left [NREG];
    bit long_on;
    int long_dst;

    logic            obs_stall, obs_fire, obs_busy;
    logic [NREG-1:0] obs_mask;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit blocked(input int r, input bit done, input int done_wa);
        if (r == 0) return 1'b0;
        return (ld_left[r] > 0) || (long_on && long_dst == r && !(done && done_wa == r));
    endfunction

    task automatic applyStimulus(input bit rst, input bit valid, input int ra1, input bit use1,
                                 input int ra2, input bit use2, input int wa, input bit wen,
                                 input int cls, input bit done, input int done_wa,
                                 input bit fl, input bit kill);
        bit              exp_stall, exp_fire;
        logic [NREG-1:0] exp_mask;
        reset           = rst;
        bus.issue_valid = valid;
        bus.issue_ra1   = 5'(ra1);
        bus.issue_ra2   = 5'(ra2);
        bus.issue_use1  = use1;
        bus.issue_use2  = use2;
        bus.issue_wa    = 5'(wa);
        bus.issue_wen   = wen;
        bus.issue_cls   = 2'(cls);
        bus.long_done   = done;
        bus.long_wa     = 5'(done_wa);
        bus.flush       = fl;
        bus.long_kill   = kill;
        @(negedge clk);
        exp_stall = !rst && valid && !fl &&
                    ((use1 && blocked(ra1, done, done_wa)) ||
                     (use2 && blocked(ra2, done, done_wa)) ||
                     (wen  && blocked(wa,  done, done_wa)) ||
                     (cls == 2 && long_on && !done));
        exp_fire  = !rst && valid && !fl && !exp_stall;
        exp_mask  = '0;
        for (int r = 1; r < NREG; r++) exp_mask[r] = (ld_left[r] > 0) || (long_on && long_dst == r);
        obs_stall = bus.stall;
        obs_fire  = bus.issue_fire;
        obs_busy  = bus.long_busy;
        obs_mask  = bus.pending_mask;
        checkOutput("stall", 32'(obs_stall), 32'(exp_stall));
        checkOutput("issue_fire", 32'(obs_fire), 32'(exp_fire));
        checkOutput("long_busy", 32'(obs_busy), 32'(long_on));
        checkOutput("pending_mask", obs_mask, exp_mask);
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < NREG; r++) ld_left[r] = 0;
            long_on  = 1'b0;
            long_dst = 0;
        end else if (fl) begin
            for (int r = 0; r < NREG; r++) ld_left[r] = 0;
            if (kill) long_on = 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) if (ld_left[r] > 0) ld_left[r]--;
            if (done && long_on && done_wa == long_dst) long_on = 1'b0;
            if (exp_fire && cls == 1 && wen && wa != 0) ld_left[wa] = LOAD_LAT;
            if (exp_fire && cls == 2 && wen) begin
                long_on  = 1'b1;
                long_dst = wa;
            end
        end
        #1;
    endtask

    task automatic issue_op(input int cls, input int ra1, input bit use1, input int wa, input bit wen,
                            input bit done = 0, input int done_wa = 0, input bit fl = 0);
        applyStimulus(0, 1, ra1, use1, 0, 0, wa, wen, cls, done, done_wa, fl, 0);
    endtask

    task automatic idle_cycle(input bit done = 0, input int done_wa = 0, input bit fl = 0, input bit kill = 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, done, done_wa, fl, kill);
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) ld_left[r] = 0;
        long_on  = 1'b0;
        long_dst = 0;
        reset = 1'b1;
        bus.issue_valid = 0; bus.issue_ra1 = 0; bus.issue_ra2 = 0; bus.issue_use1 = 0;
        bus.issue_use2 = 0;  bus.issue_wa = 0;  bus.issue_wen = 0;  bus.issue_cls = 0;
        bus.long_done = 0;   bus.long_wa = 0;   bus.flush = 0;      bus.long_kill = 0;
        @(posedge clk);
        #1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a long op
        issue_op(2, 0, 0, 7, 1);
        applyStimulus(1, 1, 7, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        checkOutput("rst_gate_stall", 32'(obs_stall), 32'd0);
        checkOutput("rst_gate_fire", 32'(obs_fire), 32'd0);
        issue_op(0, 7, 1, 1, 1);
        checkOutput("rst_busy_clear", 32'(obs_busy), 32'd0);
        checkOutput("rst_mask_clear", obs_mask, 32'd0);
        checkOutput("rst_alu_fire", 32'(obs_fire), 32'd1);

        // Load-use
        issue_op(1, 0, 0, 5, 1);
        issue_op(0, 5, 1, 6, 1);
        checkOutput("load_use_stall", 32'(obs_stall), 32'd1);
        issue_op(0, 5, 1, 6, 1);
        checkOutput("load_use_fire", 32'(obs_fire), 32'd1);
        checkOutput("load_use_cnt0", 32'(obs_mask[5]), 32'd0);

        // Long unit occupancy and same-cycle completion
        issue_op(2, 1, 1, 9, 1);
        issue_op(2, 2, 1, 10, 1);
        checkOutput("long_struct_stall", 32'(obs_stall), 32'd1);
        issue_op(2, 2, 1, 10, 1, 1, 9);
        checkOutput("long_done_fire", 32'(obs_fire), 32'd1);
        issue_op(0, 10, 1, 11, 1, 1, 10);
        checkOutput("long_wb_forward", 32'(obs_fire), 32'd1);
        idle_cycle();
        checkOutput("long_released", 32'(obs_busy), 32'd0);

        // WAW and x0
        issue_op(1, 0, 0, 0, 1);
        idle_cycle();
        checkOutput("x0_untracked", obs_mask, 32'd0);
        issue_op(1, 0, 0, 3, 1);
        issue_op(0, 0, 0, 3, 1);
        checkOutput("waw_stall", 32'(obs_stall), 32'd1);
        issue_op(0, 0, 0, 3, 1);
        checkOutput("waw_fire", 32'(obs_fire), 32'd1);

        // Flush and long_kill
        issue_op(1, 0, 0, 4, 1);
        issue_op(0, 4, 1, 8, 1, 0, 0, 1);
        checkOutput("flush_no_fire", 32'(obs_fire), 32'd0);
        checkOutput("flush_no_stall", 32'(obs_stall), 32'd0);
        idle_cycle();
        checkOutput("flush_cnt_clear", 32'(obs_mask[4]), 32'd0);
        issue_op(2, 0, 0, 6, 1);
        idle_cycle(0, 0, 1, 1);
        idle_cycle();
        checkOutput("kill_busy_clear", 32'(obs_busy), 32'd0);

        // Mismatched long_done
        issue_op(2, 0, 0, 12, 1);
        idle_cycle(1, 13);
        idle_cycle();
        checkOutput("mismatch_busy", 32'(obs_busy), 32'd1);
        issue_op(0, 12, 1, 14, 1);
        checkOutput("mismatch_stall", 32'(obs_stall), 32'd1);
        idle_cycle(1, 12);

        // Random traffic over a narrow register window to provoke hazards
        for (int i = 0; i < 800; i++) begin
            bit rst, fl, done;
            int done_wa;
            rst     = ($urandom_range(0, 59) == 0);
            fl      = ($urandom_range(0, 11) == 0);
            done    = ($urandom_range(0, 3) == 0);
            done_wa = ($urandom_range(0, 1) == 1) ? long_dst : int'($urandom_range(0, 15));
            applyStimulus(rst, 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)), done, done_wa, fl,
                          1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/operand_hazard_ctrl.md
Name: operand_hazard_ctrl

Overview:
Issue-stage scheduler placed between decode and execute. It tracks which architectural registers still have results in flight and how long each will take. It stalls any decoded instruction whose sources or destination cannot yet be satisfied by the E/M/W forwarding network that feeds the operand-select logic. It also arbitrates the single shared long-latency unit (mul/div): at most one long op is in flight at a time.

Parameters:
NREG, 32, number of architectural registers; x0 is hardwired zero
LOAD_LAT, 1, cycles after a load issues during which its result is not forwardable
CW, 2, width of the per-register load countdown; LOAD_LAT must be <= 2^CW-1

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
issue_valid  in  1  decoded instruction is present in the issue slot
issue_ra1  in  5  source register 1
issue_ra2  in  5  source register 2
issue_use1  in  1  instruction reads ra1
issue_use2  in  1  instruction reads ra2
issue_wa  in  5  destination register
issue_wen  in  1  instruction writes wa
issue_cls  in  2  producer class: 0 ALU, 1 LOAD, 2 LONG, 3 reserved (treated as ALU)
long_done  in  1  long unit writes back this cycle
long_wa  in  5  destination of the completing long op
flush  in  1  redirect: younger instructions are squashed
long_kill  in  1  abort the in-flight long op; only honoured together with flush
stall  out  1  hold the decode/issue registers this cycle
issue_fire  out  1  instruction advances to E this cycle
long_busy  out  1  long unit occupied
pending_mask  out  NREG  bit r = 1 while r has a load countdown or long op outstanding

Behaviour:
State:
- cnt[r] (CW bits) per register
- long_busy flag
- long_tag (5 bits)
Register x0 is never tracked.

hazard(r) = (r != 0) and (cnt[r] != 0 or (long_busy and long_tag == r and not (long_done and long_wa == r))).
- A long op completing in the same cycle as a read resolves through W-stage forwarding, so it does not stall.

stall = issue_valid and not flush and any of the following:
- issue_use1 and hazard(ra1)
- issue_use2 and hazard(ra2)
- issue_wen and hazard(wa) (WAW)
- issue_cls == LONG and long_busy and not long_done (structural)

issue_fire = issue_valid and not stall and not flush. Both are combinational.

Sequential update (priority top-down, each clock):
1. reset: all cnt = 0, long_busy = 0, long_tag = 0.
2. flush: all cnt cleared to 0. If long_kill, long_busy = 0. No issue is accepted this cycle.
3. Otherwise:
   - Every nonzero cnt decrements by 1, including during stall cycles, because the load keeps moving down the pipe.
   - long_done: if long_busy and long_wa == long_tag, long_busy = 0. A mismatching long_done is ignored.
   - issue_fire, LOAD, wen, wa != 0: cnt[wa] = LOAD_LAT. This overrides the decrement.
   - issue_fire, LONG, wen: long_busy = 1, long_tag = wa. If wa == 0, long_busy is still set (structural occupancy) and the tag is x0, which never hazards.
   - Same-cycle long_done and LONG issue: the new op wins; busy stays 1 with the new tag.
   - ALU issue: no state change.

Other rules:
- pending_mask is registered state only: bit r = (cnt[r] != 0) or (long_busy and long_tag == r); bit 0 is always 0.
- During reset, stall = 0 and issue_fire = 0 irrespective of inputs.

Test Plan:
- Reset mid-operation: LONG to x7 in flight, reset for 1 cycle -> next cycle long_busy = 0, pending_mask = 0, an ALU issue reading x7 fires.
- Load-use: cycle 0 LOAD wa = 5; cycle 1 ADD ra1 = 5 -> stall = 1 for exactly LOAD_LAT = 1 cycle; fires cycle 2; cnt[5] = 0 in cycle 2.
- Long unit: MUL wa = 9 fires; a second MUL waits with stall = 1 until long_done with long_wa = 9. In that cycle the second MUL fires and a consumer of x9 issued alongside it would not stall.
- WAW and x0: LOAD wa = 0 -> pending_mask stays 0; LOAD wa = 3, then ALU wa = 3 next cycle -> 1-cycle stall.
- Flush: LOAD wa = 4 fires, flush next cycle with ADD ra1 = 4 valid -> issue_fire = 0, stall = 0, cnt[4] = 0 afterwards. With long_kill = 1 and long_busy = 1 -> long_busy = 0 next cycle.
- Mismatched long_done: long_tag = 12, long_done with long_wa = 13 -> long_busy remains 1, consumer of x12 keeps stalling.
